move_commit_ctrl: RTL

//  Downstream consumer of the position selector (pos 0..9 counter + Ready flag) in the tic-tac-toe datapath.

---
 rtl/ttt_pkg.sv | 36 +++
 rtl/win_detect.sv | 31 +++
 rtl/move_commit_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
// ttt_pkg : shared cell/state encodings and winning-line table for tic-tac-toe
// Revision: 1.0
// ============================================================================
package ttt_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      P1    = 2'b01,
      P2    = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      EVAL  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int N_LINES = 8;

   // Rows, then columns, then the two diagonals
   localparam logic [3:0] WIN_LINES [N_LINES][3] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

endpackage
`default_nettype wire

// File: rtl/win_detect.sv
`default_nettype none
// ============================================================================
// win_detect : combinational three-in-a-row detector over the 9-cell board
// Revision: 1.0
// ============================================================================
module win_detect
   import ttt_pkg::*;
(
   input  logic [17:0] board_i,
   output logic [1:0]  winner_o
);

   logic [1:0] a_w, b_w, c_w;

   always_comb begin
      winner_o = EMPTY;
      a_w      = EMPTY;
      b_w      = EMPTY;
      c_w      = EMPTY;
      for (int l = 0; l < N_LINES; l++) begin
         a_w = board_i[2*WIN_LINES[l][0] +: 2];
         b_w = board_i[2*WIN_LINES[l][1] +: 2];
         c_w = board_i[2*WIN_LINES[l][2] +: 2];
         if (a_w != EMPTY && a_w == b_w && a_w == c_w) begin
            winner_o = a_w;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/move_commit_ctrl.sv
`default_nettype none
// ============================================================================
// move_commit_ctrl : validates selector moves, commits marks, tracks turn/win
// Revision: 1.0
// ============================================================================
module move_commit_ctrl
   import ttt_pkg::*;
#(
   parameter int NUM_CELLS      = 9,
   parameter int POS_W          = 4,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [POS_W-1:0]       pos,
   input  logic                   ready,
   input  logic                   new_game,
   output logic [2*NUM_CELLS-1:0] board,
   output logic                   turn,
   output logic                   move_ok,
   output logic                   move_rej,
   output logic                   timeout,
   output logic                   game_over,
   output logic [1:0]             winner
);

   localparam int CNT_W  = $clog2(NUM_CELLS + 1);
   localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IDLE_W-1:0] c_IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

   state_t                   state_q, state_d;
   logic                     ready_q, armed_q;
   logic [POS_W-1:0]         pos_q, pos_d;
   logic [2*NUM_CELLS-1:0]   board_q, board_d;
   logic                     turn_q, turn_d;
   logic [CNT_W-1:0]         move_cnt_q, move_cnt_d;
   logic [IDLE_W-1:0]        idle_cnt_q, idle_cnt_d;
   logic                     move_ok_q, move_ok_d;
   logic                     move_rej_q, move_rej_d;
   logic                     timeout_q, timeout_d;
   logic                     game_over_q, game_over_d;
   logic [1:0]               winner_q, winner_d;

   logic                     req_w, in_range_w;
   logic [POS_W-1:0]         cell_idx_w;
   logic [1:0]               win_w;
   cell_t                    mark_w;

   win_detect u_win_detect (
      .board_i  (board_q),
      .winner_o (win_w)
   );

   // armed_q blocks a ready level already high when reset releases from
   // being taken as a fresh rising edge.
   assign req_w      = ready & ~ready_q & armed_q;
   assign in_range_w = (pos_q < POS_W'(NUM_CELLS));
   assign cell_idx_w = in_range_w ? pos_q : '0;
   assign mark_w     = turn_q ? P2 : P1;

   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      board_d     = board_q;
      turn_d      = turn_q;
      move_cnt_d  = move_cnt_q;
      idle_cnt_d  = idle_cnt_q;
      winner_d    = winner_q;
      game_over_d = game_over_q;
      move_ok_d   = 1'b0;
      move_rej_d  = 1'b0;
      timeout_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_w) begin
               pos_d      = pos;
               idle_cnt_d = '0;
               state_d    = CHECK;
            end else if (TIMEOUT_CYCLES != 0) begin
               if (idle_cnt_q == c_IDLE_LAST) begin
                  timeout_d  = 1'b1;
                  turn_d     = ~turn_q;
                  idle_cnt_d = '0;
               end else begin
                  idle_cnt_d = idle_cnt_q + IDLE_W'(1);
               end
            end
         end
         CHECK: begin
            if (!in_range_w || board_q[{cell_idx_w, 1'b0} +: 2] != EMPTY) begin
               move_rej_d = 1'b1;
               state_d    = IDLE;
            end else begin
               board_d[{cell_idx_w, 1'b0} +: 2] = mark_w;
               move_cnt_d = move_cnt_q + CNT_W'(1);
               state_d    = EVAL;
            end
         end
         EVAL: begin
            move_ok_d = 1'b1;
            if (win_w != EMPTY) begin
               winner_d    = win_w;
               game_over_d = 1'b1;
               state_d     = DONE;
            end else if (move_cnt_q == CNT_W'(NUM_CELLS)) begin
               winner_d    = EMPTY;
               game_over_d = 1'b1;
               state_d     = DONE;
            end else begin
               turn_d  = ~turn_q;
               state_d = IDLE;
            end
         end
         default: ;
      endcase

      if (new_game) begin
         state_d     = IDLE;
         board_d     = '0;
         turn_d      = 1'b0;
         move_cnt_d  = '0;
         idle_cnt_d  = '0;
         winner_d    = EMPTY;
         game_over_d = 1'b0;
         move_ok_d   = 1'b0;
         move_rej_d  = 1'b0;
         timeout_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         armed_q     <= 1'b0;
         pos_q       <= '0;
         board_q     <= '0;
         turn_q      <= 1'b0;
         move_cnt_q  <= '0;
         idle_cnt_q  <= '0;
         move_ok_q   <= 1'b0;
         move_rej_q  <= 1'b0;
         timeout_q   <= 1'b0;
         game_over_q <= 1'b0;
         winner_q    <= EMPTY;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready;
         armed_q     <= armed_q | ~ready;
         pos_q       <= pos_d;
         board_q     <= board_d;
         turn_q      <= turn_d;
         move_cnt_q  <= move_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         move_ok_q   <= move_ok_d;
         move_rej_q  <= move_rej_d;
         timeout_q   <= timeout_d;
         game_over_q <= game_over_d;
         winner_q    <= winner_d;
      end
   end

   assign board     = board_q;
   assign turn      = turn_q;
   assign move_ok   = move_ok_q;
   assign move_rej  = move_rej_q;
   assign timeout   = timeout_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;

endmodule
`default_nettype wire
